// File: rtl/sev_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner.
// Adds refresh prescaling, frame-coherent capture, LZ blanking and dp.
module sev_seg_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_CNT = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [4*N_DIGITS-1:0]        value,
  input  logic [N_DIGITS-1:0]          dp_en,
  output logic [3:0]                   nibble_out,
  input  logic [7:0]                   seg_in,
  output logic [N_DIGITS-1:0]          an_n,
  output logic [7:0]                   seg_n,
  output logic [$clog2(N_DIGITS)-1:0]  digit_idx
);

  localparam int PW = $clog2(REFRESH_CNT);
  localparam int IW = $clog2(N_DIGITS);

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic                  r_lp;
  logic [N_DIGITS-1:0]   r_an;
  logic [7:0]            r_seg;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_load;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_cur_lz;
  logic                  w_cur_dp;
  logic                  w_on;
  logic [N_DIGITS-1:0]   w_sel;

  assign w_tick = en && (r_pre == PW'(REFRESH_CNT - 1));
  assign w_last = (r_idx == IW'(N_DIGITS - 1));
  // Capture only at frame boundaries so a frame never mixes two values.
  assign w_load = r_lp || !en || (w_tick && w_last);

  assign nibble_out = 4'(r_shadow >> {r_idx, 2'b00});

  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_lz   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      v_zero  = v_zero && (r_shadow[4*i +: 4] == 4'h0);
      w_lz[i] = (BLANK_LZ != 0) && (i != 0) && v_zero;
    end
  end

  assign w_cur_lz = w_lz[r_idx];
  assign w_cur_dp = dp_en[r_idx];
  // A blanked digit still lights its anode when only the dp is shown.
  assign w_on     = !(w_cur_lz && !w_cur_dp);
  assign w_sel    = {{(N_DIGITS-1){1'b0}}, w_on} << r_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_lp     <= 1'b1;
      r_an     <= '1;
      r_seg    <= 8'hFF;
    end else begin
      if (en) begin
        r_pre <= w_tick ? '0 : r_pre + PW'(1);
        if (w_tick) begin
          r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
        r_lp  <= 1'b0;
        r_an  <= ~w_sel;
        r_seg <= {~w_cur_dp, w_cur_lz ? 7'h7F : ~seg_in[6:0]};
      end else begin
        r_an  <= '1;
        r_seg <= 8'hFF;
      end
      if (w_load) begin
        r_shadow <= value;
      end
    end
  end

  assign an_n      = r_an;
  assign seg_n     = r_seg;
  assign digit_idx = r_idx;

endmodule
